// File: rtl/pool_window_stream_pkg.sv
// pool_pkg: shared pixel type, counter widths and frame geometry helpers
// Holds no ports. pixel_t is the pixel type at the default 8-bit width.
// cnt_w sizes a counter for n states and never returns less than 1 bit.
// windows_per_frame gives the number of windows emitted per frame.
package pool_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH = 5;
  localparam int DEF_IMG_HEIGHT = 5;
  localparam int DEF_STRIDE = 1;
  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int COL_W = cnt_w(DEF_IMG_WIDTH);
  localparam int ROW_W = cnt_w(DEF_IMG_HEIGHT);
  localparam int PH_W = cnt_w(DEF_STRIDE);
  function automatic int windows_per_frame(input int w, input int h, input int k, input int s);
    return ((w - k) / s + 1) * ((h - k) / s + 1);
  endfunction
endpackage

// File: rtl/pool_window_stream_if.sv
// pool_window_stream_if: pixel-in / window-out valid-ready stream bundle
// Pixel side: in_valid, in_ready, in_data.
// Window side: out_valid, out_ready, window[K][K], where [0][0] is the oldest row and leftmost column.
// When POOL_WINDOW_LAST_EN is defined, out_last is added and flags the final window of a frame.
// master: pixel source and window sink. slave: the window generator.
interface pool_window_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3
);
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_WIDTH-1:0] window;
`ifdef POOL_WINDOW_LAST_EN
  logic out_last;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, window, out_last);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, window, out_last);
`else
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, window);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, window);
`endif
endinterface

// File: rtl/pool_window_stream_line_buffer.sv
// window_line_buffer: enabled DEPTH-stage delay line holding one image row
// Ports: clk; en shifts one stage; din enters the line; dout is the entry written DEPTH shifts ago.
module window_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  always_ff @(posedge clk)
    if (en) mem <= {mem[DEPTH-2:0], din};
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/pool_window_stream.sv
// pool_window_stream: streaming KxK window generator with stride-aligned output
// Ports: clk; rst_n is an asynchronous active-low reset; bus is the slave side of pool_window_stream_if.
// Optional macro POOL_WINDOW_LAST_EN adds bus.out_last, which flags the final window of each frame.
module pool_window_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  parameter int IMG_WIDTH = 5,
  parameter int IMG_HEIGHT = 5,
  parameter int STRIDE = 1
) (
  input logic clk,
  input logic rst_n,
  pool_window_stream_if.slave bus
);
  localparam int K = KERNEL_DIM;
  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam int PW = cnt_w(STRIDE);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(STRIDE - 1);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] cph, rph;
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win;
  logic vld, acc, col_end, row_end, fire;
  // tap[r] feeds the new rightmost column of window row r; tap[K-1] is the incoming pixel
  logic [K-1:0][DATA_WIDTH-1:0] tap;
  assign bus.in_ready = !vld || bus.out_ready;
  assign acc = bus.in_valid && bus.in_ready;
  assign col_end = col == COL_LAST;
  assign row_end = row == ROW_LAST;
  assign fire = row >= ROW_FIRST && col >= COL_FIRST && rph == '0 && cph == '0;
  assign tap[K-1] = bus.in_data;
  assign bus.window = win;
  assign bus.out_valid = vld;
  // Line buffer g delays tap[g+1] by exactly one row, so tap[g] is the same column one row up
  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    window_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb (
      .clk (clk),
      .en  (acc),
      .din (tap[g+1]),
      .dout(tap[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      cph <= '0;
      rph <= '0;
      win <= '0;
      vld <= 1'b0;
    end else begin
      if (acc) begin
        col <= col_end ? '0 : col + 1'b1;
        cph <= (col < COL_FIRST || cph == PH_LAST) ? '0 : cph + 1'b1;
        if (col_end) begin
          row <= row_end ? '0 : row + 1'b1;
          rph <= (row < ROW_FIRST || rph == PH_LAST) ? '0 : rph + 1'b1;
        end
        for (int r = 0; r < K; r++) win[r] <= {tap[r], win[r][K-1:1]};
      end
      vld <= acc ? fire : vld && !bus.out_ready;
    end
`ifdef POOL_WINDOW_LAST_EN
  localparam logic [CW-1:0] COL_FIN = CW'(K - 1 + STRIDE * ((IMG_WIDTH - K) / STRIDE));
  localparam logic [RW-1:0] ROW_FIN = RW'(K - 1 + STRIDE * ((IMG_HEIGHT - K) / STRIDE));
  logic last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b0;
    else last_q <= acc ? fire && row == ROW_FIN && col == COL_FIN : last_q && !bus.out_ready;
  assign bus.out_last = last_q;
`endif
endmodule

// File: tb/tb_pool_window_stream.sv
// tb_pool_window_stream: directed and randomized frames on stride-1 and stride-2 instances against a frame model
module tb_pool_window_stream;
  import pool_pkg::*;
  localparam int DW = 8, K = 3, W = 5, H = 5, NP = W * H, NB = K * K * DW;
`ifdef POOL_WINDOW_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif
  localparam logic [NB-1:0] FIRST = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0, got_a = 0, got_b = 0;
  int pos [2];
  logic [DW-1:0] img [2][H][W];
  logic [NB:0] q_a [$];
  logic [NB:0] q_b [$];
  logic last_a, last_b;
  always #5 clk = ~clk;
  pool_window_stream_if #(.DATA_WIDTH(DW), .KERNEL_DIM(K)) a ();
  pool_window_stream_if #(.DATA_WIDTH(DW), .KERNEL_DIM(K)) b ();
  pool_window_stream #(.DATA_WIDTH(DW), .KERNEL_DIM(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave));
  pool_window_stream #(.DATA_WIDTH(DW), .KERNEL_DIM(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));
  assign b.in_valid = a.in_valid && a.in_ready;
  assign b.in_data = a.in_data;
  assign b.out_ready = 1'b1;
`ifdef POOL_WINDOW_LAST_EN
  assign last_a = a.out_last;
  assign last_b = b.out_last;
`else
  assign last_a = 1'b0;
  assign last_b = 1'b0;
`endif
  task automatic check(input string tag, input logic [NB:0] obs, input logic [NB:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_acc(input int s, input logic [DW-1:0] d);
    int st = s == 0 ? 1 : 2;
    int r = pos[s] / W;
    int c = pos[s] % W;
    logic [NB:0] e = '0;
    img[s][r][c] = d;
    pos[s] = (pos[s] + 1) % NP;
    if (r >= K - 1 && c >= K - 1 && (r - K + 1) % st == 0 && (c - K + 1) % st == 0) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) e[(i*K+j)*DW +: DW] = img[s][r-K+1+i][c-K+1+j];
      e[NB] = LAST_EN && r == H - 1 - (H - K) % st && c == W - 1 - (W - K) % st;
      if (s == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (a.out_valid && a.out_ready) begin
        if (q_a.size() == 0) check("extra_a", {{NB{1'b0}}, a.out_valid}, '0);
        else begin
          check("win_a", {last_a, a.window}, q_a.pop_front());
          got_a++;
        end
      end
      if (b.out_valid && b.out_ready) begin
        if (q_b.size() == 0) check("extra_b", {{NB{1'b0}}, b.out_valid}, '0);
        else begin
          check("win_b", {last_b, b.window}, q_b.pop_front());
          got_b++;
        end
      end
      if (a.in_valid && a.in_ready) model_acc(0, a.in_data);
      if (b.in_valid && b.in_ready) model_acc(1, b.in_data);
    end
  task automatic send_frame(input int base, input bit rnd, input bit stall, input int n);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n) begin
      a.in_valid = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
      a.out_ready = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
      a.in_data = rnd ? DW'($urandom) : DW'(base + i);
      if (stall && a.out_valid) begin
        stall = 1'b0;
        check("first_win", {1'b0, a.window}, {1'b0, FIRST});
        a.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_ready", {{NB{1'b0}}, a.in_ready}, '0);
          check("stall_win", {1'b0, a.window}, {1'b0, FIRST});
          @(posedge clk);
          #1;
        end
        a.out_ready = 1'b1;
      end
      @(negedge clk);
      acc = a.in_valid && a.in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      if (++guard > 4000) begin
        check("timeout", (NB+1)'(i), (NB+1)'(n));
        break;
      end
    end
    a.in_valid = 1'b0;
  endtask
  task automatic settle(input int nfr);
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("count_a", (NB+1)'(got_a), (NB+1)'(nfr * windows_per_frame(W, H, K, 1)));
    check("count_b", (NB+1)'(got_b), (NB+1)'(nfr * windows_per_frame(W, H, K, 2)));
    check("left_a", (NB+1)'(q_a.size()), '0);
    check("left_b", (NB+1)'(q_b.size()), '0);
    got_a = 0;
    got_b = 0;
  endtask
  initial begin
    a.in_valid = 1'b0;
    a.in_data = '0;
    a.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", {{NB{1'b0}}, a.out_valid}, '0);
    check("rst_win_a", {1'b0, a.window}, '0);
    check("rst_valid_b", {{NB{1'b0}}, b.out_valid}, '0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {{NB{1'b0}}, a.in_ready}, (NB+1)'(1));
    send_frame(0, 1'b0, 1'b0, NP);
    settle(1);
    send_frame(0, 1'b0, 1'b1, NP);
    settle(1);
    send_frame(0, 1'b0, 1'b0, NP);
    send_frame(100, 1'b0, 1'b0, NP);
    settle(2);
    send_frame(0, 1'b0, 1'b0, 14);
    check("pre_arst_valid", {{NB{1'b0}}, a.out_valid}, (NB+1)'(1));
    rst_n = 1'b0;
    #1;
    check("arst_valid_a", {{NB{1'b0}}, a.out_valid}, '0);
    check("arst_win_a", {1'b0, a.window}, '0);
    check("arst_valid_b", {{NB{1'b0}}, b.out_valid}, '0);
    q_a.delete();
    q_b.delete();
    pos = '{0, 0};
    got_a = 0;
    got_b = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(0, 1'b0, 1'b0, NP);
    settle(1);
    repeat (3) send_frame(0, 1'b1, 1'b0, NP);
    settle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
